// File: rtl/spi_pkg.sv
// Shared state encoding and default parameter values for the SPI arbiter.
package spi_pkg;

  localparam int N_REQ_DEF          = 4;
  localparam int DATA_W_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_LOW,
    WAIT_HIGH,
    RESP
  } state_e;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin winner search: first requester strictly after last_grant, wrapping at N_REQ-1.
module spi_rr_arbiter import spi_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [$clog2(N_REQ)-1:0] grant,
  output logic                     any_req
);

  localparam int IDX_W = $clog2(N_REQ);

  always_comb begin
    int j;
    grant   = '0;
    any_req = 1'b0;
    j       = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = int'(last_grant) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any_req && req[j[IDX_W-1:0]]) begin
        any_req = 1'b1;
        grant   = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among N_REQ requesters.
// Optional watchdog on the chip-select waits: define SPI_ARBITER_TIMEOUT_EN.
module spi_arbiter import spi_pkg::*; #(
  parameter int N_REQ          = N_REQ_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]              ack,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          rsp_err,
  output logic                          busy,
  output logic                          m_start,
  output logic [DATA_W-1:0]             m_din,
  input  logic                          m_cs,
  input  logic [DATA_W-1:0]             m_dout
);

  localparam int IDX_W = $clog2(N_REQ);

  state_e           state, state_nxt;
  logic [IDX_W-1:0] last_grant, rr_grant, pick, win_idx;
  logic             any_req, cs_q, cs_rise, tmo, in_wait;

  spi_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .any_req    (any_req)
  );

  assign in_wait = (state == WAIT_LOW) || (state == WAIT_HIGH);
  assign cs_rise = m_cs && !cs_q;

`ifdef SPI_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  // counts cycles spent in either wait state; fires on the last one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cnt <= '0;
    else if (in_wait) cnt <= cnt + 1'b1;
    else              cnt <= '0;
  end

  assign tmo = in_wait && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             err_q <= 1'b0;
    else if (state == WAIT_HIGH && cs_rise) err_q <= 1'b0;
    else if (tmo)                           err_q <= 1'b1;
  end

  assign rsp_err = (state == RESP) && err_q;
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any_req) state_nxt = LOAD;
      LOAD:      state_nxt = START;
      START:     state_nxt = WAIT_LOW;
      WAIT_LOW:  if (tmo) state_nxt = RESP;
                 else if (!m_cs) state_nxt = WAIT_HIGH;
      WAIT_HIGH: if (cs_rise || tmo) state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pick       <= '0;
      win_idx    <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      m_din      <= '0;
      rsp_data   <= '0;
      cs_q       <= 1'b1;
    end else begin
      cs_q <= m_cs;
      if (state == IDLE && any_req) pick <= rr_grant;
      // data is captured here so a requester may drop req once granted
      if (state == LOAD) begin
        win_idx <= pick;
        m_din   <= req_data[pick];
      end
      if (state == WAIT_HIGH && cs_rise) rsp_data <= m_dout;
      else if (tmo)                      rsp_data <= '0;
      if (state == RESP) last_grant <= win_idx;
    end
  end

  assign busy    = (state != IDLE);
  assign m_start = (state == START);
  assign ack     = (state == RESP) ? (N_REQ'(1) << win_idx) : '0;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: vector table plus reset, contention, drop and timeout sequences.
module tb_spi_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req;
  logic [3:0][7:0]  req_data;
  logic [3:0]       ack;
  logic [7:0]       rsp_data;
  logic             rsp_err, busy, m_start;
  logic [7:0]       m_din;
  logic             m_cs;
  logic [7:0]       m_dout;

  int n_chk  = 0;
  int n_fail = 0;

  spi_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .m_start(m_start),
    .m_din(m_din), .m_cs(m_cs), .m_dout(m_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  req;
    int          idx;
    logic [7:0]  rsp;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    while (!m_start && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // slave model: cs low for a few cycles, then return byte on cs rising
  task automatic slave_xfer(input logic [7:0] rsp, output logic [3:0] a,
                            output logic [7:0] d, output logic e);
    int k;
    m_cs = 1'b0;
    repeat (3) @(negedge clk);
    m_dout = rsp;
    m_cs   = 1'b1;
    a = '0; d = '0; e = 1'b0; k = 0;
    while (a == 0 && k < 20) begin
      @(negedge clk);
      k++;
      if (ack != 0) begin a = ack; d = rsp_data; e = rsp_err; end
    end
  endtask

  initial begin
    int lat, got, seen;
    logic [3:0] a;
    logic [7:0] d;
    logic       e;
    logic [31:0] vd;

    tv[0] = '{32'h1122A533, 4'b0010, 1, 8'h3C};
    tv[1] = '{32'h44556677, 4'b1111, 2, 8'h81};
    tv[2] = '{32'h8899AABB, 4'b1011, 3, 8'h42};
    tv[3] = '{32'hC0DEF00D, 4'b1001, 0, 8'h7E};
    tv[4] = '{32'h13579BDF, 4'b1001, 3, 8'h00};
    tv[5] = '{32'h2468ACE0, 4'b0110, 1, 8'hFF};
    tv[6] = '{32'hDEADBEEF, 4'b0001, 0, 8'h5A};

    reset = 1'b0; req = '0; req_data = '0; m_cs = 1'b1; m_dout = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_m_start", 32'(m_start), 0);
    chk("rst_m_din", 32'(m_din), 0);
    reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      req_data = tv[v].data;
      req      = tv[v].req;
      vd       = tv[v].data;
      wait_start(lat);
      chk("vec_latency", 32'(lat), 2);
      chk("vec_m_din", 32'(m_din), 32'(vd[tv[v].idx*8 +: 8]));
      chk("vec_busy", 32'(busy), 1);
      slave_xfer(tv[v].rsp, a, d, e);
      chk("vec_ack", 32'(a), 32'(4'b0001 << tv[v].idx));
      chk("vec_rsp_data", 32'(d), 32'(tv[v].rsp));
      chk("vec_rsp_err", 32'(e), 0);
      req = '0;
      @(negedge clk);
      chk("vec_ack_pulse", 32'(ack), 0);
      chk("vec_busy_clr", 32'(busy), 0);
    end

    // m_cs low while idle must not start anything
    m_cs = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || m_start || ack != 0) seen++;
    end
    chk("idle_cs_low", 32'(seen), 0);
    m_cs = 1'b1;
    @(negedge clk);

    // req dropped after grant still completes
    req_data = 32'h0BADCAFE;
    req = 4'b0100;
    wait_start(lat);
    req = '0;
    chk("drop_m_din", 32'(m_din), 32'h000000AD);
    slave_xfer(8'h99, a, d, e);
    chk("drop_ack", 32'(a), 32'h4);
    chk("drop_rsp", 32'(d), 32'h99);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack != 0) seen++;
    end
    chk("drop_single_ack", 32'(seen), 0);

    // reset during WAIT_HIGH
    req_data = 32'h5566778E;
    req = 4'b1000;
    wait_start(lat);
    m_cs = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_m_din", 32'(m_din), 0);
    chk("mid_rst_m_start", 32'(m_start), 0);
    chk("mid_rst_rsp", 32'({rsp_data, rsp_err}), 0);
    m_cs = 1'b1;
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack != 0 || busy) seen++;
    end
    chk("mid_no_ack", 32'(seen), 0);

    // contention after reset: 0,1,2,3,0 with own byte echoed
    req_data = 32'hF3E2D1C0;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_start(lat);
      chk("rr_start", 32'(m_start), 1);
      slave_xfer(m_din, a, d, e);
      chk("rr_ack", 32'(a), 32'(4'b0001 << (t % 4)));
      chk("rr_echo", 32'(d), 32'(req_data[t % 4]));
    end
    req = '0;
    repeat (3) @(negedge clk);

    // chip select never toggles after m_start
    req_data = 32'h00000077;
    req = 4'b0001;
    wait_start(lat);
    got = 0;
    a = '0; d = 8'hEE; e = 1'b0;
`ifdef SPI_ARBITER_TIMEOUT_EN
    while (got == 0 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ack != 0) begin got = lat; a = ack; d = rsp_data; e = rsp_err; end
    end
    req = '0;
    chk("tmo_cycles", 32'(got), 19);
    chk("tmo_ack", 32'(a), 32'h1);
    chk("tmo_err", 32'(e), 1);
    chk("tmo_rsp_data", 32'(d), 0);
`else
    repeat (40) begin
      @(negedge clk);
      if (ack != 0) got++;
    end
    chk("no_tmo_ack", 32'(got), 0);
    chk("no_tmo_busy", 32'(busy), 1);
    slave_xfer(8'h6D, a, d, e);
    req = '0;
    chk("no_tmo_late_ack", 32'(a), 32'h1);
    chk("no_tmo_rsp", 32'(d), 32'h6D);
    chk("no_tmo_err", 32'(e), 0);
`endif
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
